// File: rtl/fuzzifier_trap3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fuzzifier_trap3                                                          |
// | Three-set trapezoidal fuzzifier: signed 8-bit crisp input to Q1.15       |
// | NEG/ZERO/POS membership degrees, registered with one cycle of latency.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fuzzifier_trap3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  x,
  input  logic [7:0]  a_neg,
  input  logic [7:0]  b_neg,
  input  logic [7:0]  c_neg,
  input  logic [7:0]  d_neg,
  input  logic [7:0]  a_zero,
  input  logic [7:0]  b_zero,
  input  logic [7:0]  c_zero,
  input  logic [7:0]  d_zero,
  input  logic [7:0]  a_pos,
  input  logic [7:0]  b_pos,
  input  logic [7:0]  c_pos,
  input  logic [7:0]  d_pos,
  output logic [15:0] mu_neg,
  output logic [15:0] mu_zero,
  output logic [15:0] mu_pos,
  output logic        out_valid
);

  localparam logic [15:0] C_FULL = 16'h7FFF;

  // Edges share one divider per set: the active branch selects numerator and divisor.
  function automatic logic [15:0] memb(input logic [7:0] xv, input logic [7:0] av,
                                       input logic [7:0] bv, input logic [7:0] cv,
                                       input logic [7:0] dv);
    logic signed [8:0] xe, ae, be, ce, de;
    logic signed [8:0] num_d, den_d;
    logic [23:0]       q;
    logic [15:0]       m;
    logic              use_div;
    xe = {xv[7], xv};
    ae = {av[7], av};
    be = {bv[7], bv};
    ce = {cv[7], cv};
    de = {dv[7], dv};
    num_d   = '0;
    den_d   = 9'sd1;
    use_div = 1'b0;
    m       = '0;
    if (xe < ae || xe > de) begin
      m = '0;
    end else if (xe < be) begin
      num_d   = xe - ae;
      den_d   = be - ae;
      use_div = 1'b1;
    end else if (xe <= ce) begin
      m = C_FULL;
    end else begin
      num_d   = de - xe;
      den_d   = de - ce;
      use_div = 1'b1;
    end
    q = {num_d, 15'b0} / {15'b0, den_d};
    if (use_div) begin
      m = (q > {8'b0, C_FULL}) ? C_FULL : {1'b0, q[14:0]};
    end
    return m;
  endfunction

  logic [15:0] w_mu_neg, w_mu_zero, w_mu_pos;
  logic [15:0] r_mu_neg, r_mu_zero, r_mu_pos;
  logic        r_out_valid;

  always_comb begin
    w_mu_neg  = memb(x, a_neg,  b_neg,  c_neg,  d_neg);
    w_mu_zero = memb(x, a_zero, b_zero, c_zero, d_zero);
    w_mu_pos  = memb(x, a_pos,  b_pos,  c_pos,  d_pos);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mu_neg    <= '0;
      r_mu_zero   <= '0;
      r_mu_pos    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_mu_neg  <= w_mu_neg;
        r_mu_zero <= w_mu_zero;
        r_mu_pos  <= w_mu_pos;
      end
    end
  end

  assign mu_neg    = r_mu_neg;
  assign mu_zero   = r_mu_zero;
  assign mu_pos    = r_mu_pos;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fuzzifier_trap3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fuzzifier_trap3                                                       |
// | Directed and random stimulus against an arithmetic membership model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fuzzifier_trap3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] x = '0;
  logic signed [7:0] bk [0:2][0:3];
  logic [15:0]       mu_neg, mu_zero, mu_pos;
  logic              out_valid;

  int nchecks = 0;
  int nerrors = 0;
  int e_mu [0:2];

  always #5 clk = ~clk;

  fuzzifier_trap3 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x),
    .a_neg(bk[0][0]),  .b_neg(bk[0][1]),  .c_neg(bk[0][2]),  .d_neg(bk[0][3]),
    .a_zero(bk[1][0]), .b_zero(bk[1][1]), .c_zero(bk[1][2]), .d_zero(bk[1][3]),
    .a_pos(bk[2][0]),  .b_pos(bk[2][1]),  .c_pos(bk[2][2]),  .d_pos(bk[2][3]),
    .mu_neg(mu_neg), .mu_zero(mu_zero), .mu_pos(mu_pos), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nchecks++;
    if (obs != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trapezoid membership straight from its piecewise definition.
  function automatic int ref_mu(input int xv, input int a, input int b, input int c, input int d);
    int r;
    if (xv < a || xv > d)  r = 0;
    else if (xv < b)       r = ((xv - a) * 32768) / (b - a);
    else if (xv <= c)      r = 32767;
    else                   r = ((d - xv) * 32768) / (d - c);
    if (r > 32767) r = 32767;
    return r;
  endfunction

  task automatic set_bk(input int s, input int a, input int b, input int c, input int d);
    bk[s][0] = 8'(a); bk[s][1] = 8'(b); bk[s][2] = 8'(c); bk[s][3] = 8'(d);
  endtask

  task automatic check_outs(input string tag, input int ov);
    chk({tag, ".neg"},  int'(mu_neg),  e_mu[0]);
    chk({tag, ".zero"}, int'(mu_zero), e_mu[1]);
    chk({tag, ".pos"},  int'(mu_pos),  e_mu[2]);
    chk({tag, ".vld"},  int'(out_valid), ov);
  endtask

  task automatic apply(input string tag, input int xv);
    x = 8'(xv);
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++)
      e_mu[s] = ref_mu(xv, int'(bk[s][0]), int'(bk[s][1]), int'(bk[s][2]), int'(bk[s][3]));
    @(posedge clk); #1;
    check_outs(tag, 1);
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    x = 8'($urandom);
    @(posedge clk); #1;
    check_outs(tag, 0);
  endtask

  initial begin
    int v [0:3];
    int t;
    set_bk(0, -64, 0, 0, 64);
    set_bk(1, -16, -1, 1, 16);
    set_bk(2, 0, 32, 64, 80);
    for (int s = 0; s < 3; s++) e_mu[s] = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_outs("reset", 0);

    apply("x_m127", -127);
    chk("x_m127.abs", int'(mu_neg), 0);
    apply("x_p127", 127);
    apply("x_m32", -32);
    chk("mid_neg_lo", int'(mu_neg), 16384);
    apply("x_p32", 32);
    chk("mid_neg_hi", int'(mu_neg), 16384);
    chk("plat_pos", int'(mu_pos), 32767);
    apply("x_p72", 72);
    chk("mid_pos_fall", int'(mu_pos), 16384);
    apply("x_0", 0);
    chk("peak_zero", int'(mu_zero), 32767);
    idle("hold1");

    set_bk(2, 0, 0, 64, 80);
    apply("step_0", 0);
    chk("step_0.abs", int'(mu_pos), 32767);
    apply("step_m1", -1);
    chk("step_m1.abs", int'(mu_pos), 0);
    apply("z_m16", -16);
    chk("z_m16.abs", int'(mu_zero), 0);
    apply("z_m8", -8);
    chk("z_m8.abs", int'(mu_zero), 17476);

    set_bk(2, 0, 32, 64, 80);
    apply("pipe0", -32);
    apply("pipe1", 0);
    chk("pipe1.abs", int'(mu_neg), 32767);
    apply("pipe2", 32);
    idle("hold2");

    x = 8'sd0; in_valid = 1'b1; rst = 1'b1;
    for (int s = 0; s < 3; s++) e_mu[s] = 0;
    @(posedge clk); #1;
    check_outs("rst_prio", 0);
    rst = 1'b0;

    apply("extreme_lo", -128);
    set_bk(0, -128, -128, 127, 127);
    apply("full_range_lo", -128);
    apply("full_range_hi", 127);
    set_bk(1, -128, 127, 127, 127);
    apply("wide_slope", 126);

    for (int i = 0; i < 300; i++) begin
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 4; k++) v[k] = int'($urandom_range(0, 255)) - 128;
        if (i % 2 == 0) begin
          for (int p = 0; p < 3; p++)
            for (int q = 0; q < 3 - p; q++)
              if (v[q] > v[q+1]) begin t = v[q]; v[q] = v[q+1]; v[q+1] = t; end
        end
        set_bk(s, v[0], v[1], v[2], v[3]);
      end
      if ($urandom_range(0, 7) == 0) idle("rnd_idle");
      else apply("rnd", int'($urandom_range(0, 255)) - 128);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
`default_nettype wire
